// File: rtl/morse_symbol_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : morse_symbol_sequencer
//  Description : Times debounced key presses and idle gaps, classifies each
//                press as a dot or a dash, assembles up to five symbols into
//                a left-aligned character code and emits character-complete
//                and word-gap events for the downstream decoder.
//  Revision    : 1.0 - initial release
// ============================================================================
module morse_symbol_sequencer #(
   parameter int unsigned DASH_TICKS    = 30_000_000,
   parameter int unsigned ILLEGAL_TICKS = 100_000_000,
   parameter int unsigned CHAR_TICKS    = 175_000_000,
   parameter int unsigned WORD_TICKS    = 250_000_000,
   parameter int unsigned CNT_W         = 28
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       btn_i,
   output logic       sym_valid_o,
   output logic       sym_o,
   output logic       char_valid_o,
   output logic [4:0] char_code_o,
   output logic [2:0] char_len_o,
   output logic       char_err_o,
   output logic       word_o,
   output logic       busy_o
);

   // Thresholds expressed at counter width so every compare is width-matched.
   localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
   localparam logic [CNT_W-1:0] DASH_CNT     = CNT_W'(DASH_TICKS);
   localparam logic [CNT_W-1:0] ILLEGAL_LAST = CNT_W'(ILLEGAL_TICKS - 1);
   localparam logic [CNT_W-1:0] CHAR_CNT     = CNT_W'(CHAR_TICKS);
   localparam logic [CNT_W-1:0] CHAR_LAST    = CNT_W'(CHAR_TICKS - 1);
   localparam logic [CNT_W-1:0] WORD_LAST    = CNT_W'(WORD_TICKS - 1);
   localparam logic [2:0]       MAX_LEN      = 3'd5;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_PRESS = 3'd1,
      ST_LONG  = 3'd2,
      ST_GAP   = 3'd3,
      ST_CGAP  = 3'd4
   } state_t;

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic [4:0]       sym_buf;
   logic [2:0]       sym_len;
   logic             sym_err;
   logic             is_dash;

   // Press length at the release sample decides dot versus dash.
   assign is_dash = (cnt >= DASH_CNT);

   // Main sequencer: duration counting, symbol assembly and event pulses.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= ST_IDLE;
         cnt          <= '0;
         sym_buf      <= '0;
         sym_len      <= '0;
         sym_err      <= 1'b0;
         sym_valid_o  <= 1'b0;
         sym_o        <= 1'b0;
         char_valid_o <= 1'b0;
         char_code_o  <= '0;
         char_len_o   <= '0;
         char_err_o   <= 1'b0;
         word_o       <= 1'b0;
         busy_o       <= 1'b0;
      end else begin
         sym_valid_o  <= 1'b0;
         char_valid_o <= 1'b0;
         word_o       <= 1'b0;
         case (state)
            ST_IDLE: begin
               cnt <= '0;
               if (btn_i) begin
                  state  <= ST_PRESS;
                  cnt    <= CNT_ONE;
                  busy_o <= 1'b1;
               end
            end
            ST_PRESS: begin
               if (btn_i) begin
                  if (cnt == ILLEGAL_LAST) begin
                     // Press is too long to be a symbol; poison the character.
                     sym_err <= 1'b1;
                     state   <= ST_LONG;
                     cnt     <= '0;
                  end else begin
                     cnt <= cnt + CNT_ONE;
                  end
               end else begin
                  if (sym_len < MAX_LEN) begin
                     sym_buf[3'd4 - sym_len] <= is_dash;
                     sym_len                 <= sym_len + 3'd1;
                     sym_valid_o             <= 1'b1;
                     sym_o                   <= is_dash;
                  end else begin
                     // Sixth symbol: buffer is full, flag overflow only.
                     sym_err <= 1'b1;
                  end
                  state <= ST_GAP;
                  cnt   <= CNT_ONE;
               end
            end
            ST_LONG: begin
               if (!btn_i) begin
                  state <= ST_GAP;
                  cnt   <= CNT_ONE;
               end
            end
            ST_GAP: begin
               if (btn_i) begin
                  state <= ST_PRESS;
                  cnt   <= CNT_ONE;
               end else if (cnt == CHAR_LAST) begin
                  char_valid_o <= 1'b1;
                  char_code_o  <= sym_buf;
                  char_len_o   <= sym_len;
                  char_err_o   <= sym_err;
                  sym_buf      <= '0;
                  sym_len      <= '0;
                  sym_err      <= 1'b0;
                  state        <= ST_CGAP;
                  cnt          <= CHAR_CNT;
               end else begin
                  cnt <= cnt + CNT_ONE;
               end
            end
            ST_CGAP: begin
               if (btn_i) begin
                  state <= ST_PRESS;
                  cnt   <= CNT_ONE;
               end else if (cnt == WORD_LAST) begin
                  word_o <= 1'b1;
                  state  <= ST_IDLE;
                  cnt    <= '0;
                  busy_o <= 1'b0;
               end else begin
                  cnt <= cnt + CNT_ONE;
               end
            end
            default: begin
               state  <= ST_IDLE;
               cnt    <= '0;
               busy_o <= 1'b0;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: doc/morse_symbol_sequencer.md
# morse_symbol_sequencer

Timing controller between the button debouncer and the Morse character decoder. It measures press and idle durations of the debounced key in clock ticks and classifies each press as a dot or dash. Symbols are assembled into a left-aligned 5-bit code, MSB first, using the codebase encoding (dot = 0, dash = 1). It emits character-complete and word-gap events that sequence the downstream decode and display logic.

## Interface
- DASH_TICKS, 30_000_000: minimum pressed samples for a dash.
- ILLEGAL_TICKS, 100_000_000: pressed samples at which a press becomes illegal.
- CHAR_TICKS, 175_000_000: idle samples that close a character.
- WORD_TICKS, 250_000_000: idle samples that close a word. Required ordering: CHAR_TICKS < WORD_TICKS.
- CNT_W, 28: duration counter width. It must hold WORD_TICKS.
- clk  in  1  system clock. One clock domain only.
- rst  in  1  asynchronous, active-high reset.
- btn_i  in  1  debounced key level (1 = pressed), synchronous to clk.
- sym_valid_o  out  1  one-cycle pulse when a symbol is accepted.
- sym_o  out  1  accepted symbol (0 dot, 1 dash). Valid with sym_valid_o.
- char_valid_o  out  1  one-cycle pulse when a character closes.
- char_code_o  out  5  symbols left-aligned, MSB is the first symbol. Unused LSBs are 0.
- char_len_o  out  3  symbol count, 0..5.
- char_err_o  out  1  the character contained an illegal press or a symbol overflow.
- word_o  out  1  one-cycle pulse at a word gap.
- busy_o  out  1  high in any state other than IDLE.

## Operation
- Counter cnt (CNT_W bits) counts samples spent in the current state. The symbol buffer consists of buf[4:0], len[2:0] and err.
- IDLE: cnt = 0. If btn_i = 1, go to PRESS with cnt = 1.
- PRESS:
  - btn_i = 1 and cnt = ILLEGAL_TICKS-1: set err and go to LONG. No symbol is produced.
  - btn_i = 1 otherwise: cnt++.
  - btn_i = 0: classify d = cnt. d < DASH_TICKS is a dot; DASH_TICKS ≤ d ≤ ILLEGAL_TICKS-1 is a dash.
  - If len < 5: write the symbol to buf[4-len], len++, pulse sym_valid_o. If len = 5: set err, no pulse, buffer unchanged.
  - After the release, go to GAP with cnt = 1.
- LONG: wait for btn_i = 0, then go to GAP with cnt = 1.
- GAP:
  - btn_i = 1: go to PRESS with cnt = 1. The same character continues.
  - btn_i = 0 and cnt = CHAR_TICKS-1: pulse char_valid_o with buf, len, err. Clear buf, len and err. Go to CGAP with cnt = CHAR_TICKS.
  - Otherwise cnt++.
- CGAP:
  - btn_i = 1: go to PRESS with cnt = 1. A new character starts.
  - btn_i = 0 and cnt = WORD_TICKS-1: pulse word_o and go to IDLE.
  - Otherwise cnt++.
- A character closes even when len = 0 but err = 1 (for example, only an illegal press).
- A press sampled on the same cycle as a threshold match wins. No close event fires on that cycle.
- char_code_o, char_len_o and char_err_o hold their last values until the next char_valid_o.

## Timing
- All outputs are registered.
- sym_valid_o asserts the cycle after the release sample.
- char_valid_o asserts the cycle after the CHAR_TICKS-th consecutive idle sample.
- word_o asserts the cycle after the WORD_TICKS-th consecutive idle sample.
- Pulses are exactly one cycle wide. No back-pressure: consumers must accept pulses every cycle.
- Reset values: every output is 0, the state is IDLE, buf/len/err/cnt are 0.
- Reset mid-character discards the partial character. No char_valid_o or word_o pulse is produced.
- btn_i high during reset release: the press begins on the first sample after reset with cnt = 1.
- cnt never exceeds WORD_TICKS-1, so there is no wrap-around.

## Test plan
Use sim parameters DASH_TICKS=4, ILLEGAL_TICKS=10, CHAR_TICKS=16, WORD_TICKS=24.
1. Press 2 samples, then idle 24 samples:
   - sym_valid_o with sym_o = 0.
   - char_valid_o 16 cycles after the release sample, with code 00000, len 1, err 0.
   - word_o 8 cycles after char_valid_o.
   - busy_o = 0 afterwards.
2. Presses of 4, 3, 9 and 1 samples separated by 5-sample gaps:
   - sym_o sequence 1, 0, 1, 0 (tests the dash boundary at 4 and the maximum legal dash at 9).
   - char code 10100, len 4, err 0 (the letter C).
3. Six 2-sample presses with 2-sample gaps:
   - Five sym_valid_o pulses; the sixth press produces none.
   - char code 00000, len 5, err 1.
4. Press held for 12 samples:
   - No sym_valid_o; the state enters LONG at the 10th sample.
   - After release plus 16 idle samples: char len 0, err 1, code 00000.
5. Dot, 15 idle samples, dash, 16 idle samples:
   - No char_valid_o after the first gap.
   - A single char with code 01000, len 2 (the letter A).
   - A press at idle sample 20 suppresses word_o.
6. Assert rst after two accepted dashes:
   - All outputs go to 0 immediately.
   - No char_valid_o or word_o follows.
   - A following 1-sample press plus a 16-sample gap yields code 00000, len 1.
